// File: rtl/seg_result_display_if.sv
// Handshake and display bundle between the convolution result source and seg_result_display.
interface seg_result_display_if #(
  parameter int VAL_W  = 12,
  parameter int DIGITS = 4
);
  logic [VAL_W-1:0]    value_in;
  logic                value_valid;
  logic                busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic                overflow;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;

  modport master (
    output value_in, value_valid,
    input  busy, bcd_out, overflow, seg_n, an_n
  );

  modport slave (
    input  value_in, value_valid,
    output busy, bcd_out, overflow, seg_n, an_n
  );
endinterface

// File: rtl/seg_result_display.sv
// Captures a binary result, converts it to BCD by sequential double-dabble and scans it onto a
// common-anode 7-segment display. Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// state   | meaning
// IDLE    | waiting for value_valid; display shows last committed value
// CONVERT | one add-3/shift iteration per cycle, VAL_W iterations
// COMMIT  | scratch BCD and overflow flag copied to the outputs
module seg_result_display #(
  parameter int VAL_W       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst,
  seg_result_display_if.slave bus
);

  localparam int CNT_W = $clog2(VAL_W);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = VAL_W + 28;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Wide enough to hold 10^8 regardless of VAL_W.
  localparam logic [EXT_W-1:0] LIMIT = EXT_W'(pow10(DIGITS));

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t              state, state_next;
  logic                load, shift_en, commit, busy;
  logic [VAL_W-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch, adj;
  logic [CNT_W-1:0]    iter_cnt;
  logic                ovf_latched, ovf_now;
  logic [4*DIGITS-1:0] bcd_q;
  logic                ovf_q;
  logic [REF_W-1:0]    refresh_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [6:0]          seg_q, seg_next;
  logic [DIGITS-1:0]   an_q;
  logic [3:0]          sel_digit;
  logic                lead_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.value_valid) state_next = CONVERT;
      CONVERT: if (iter_cnt == CNT_W'(VAL_W - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    load = bus.value_valid;
      CONVERT: begin shift_en = 1'b1; busy = 1'b1; end
      COMMIT:  begin commit   = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign ovf_now = {28'd0, bus.value_in} >= LIMIT;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
  end

  // Carry out of the top digit is dropped, so the result is value mod 10^DIGITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      scratch     <= '0;
      iter_cnt    <= '0;
      ovf_latched <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (load) begin
        shreg       <= bus.value_in;
        scratch     <= '0;
        iter_cnt    <= '0;
        ovf_latched <= ovf_now;
      end else if (shift_en) begin
        {scratch, shreg} <= {adj, shreg} << 1;
        iter_cnt         <= iter_cnt + 1'b1;
      end
      if (commit) begin
        bcd_q <= scratch;
        ovf_q <= ovf_latched;
      end
    end
  end

  assign sel_digit = bcd_q[4*digit_idx +: 4];

  always_comb begin
    lead_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lead_blank = (digit_idx != '0);
    for (int i = 0; i < DIGITS; i++)
      if (i >= int'(digit_idx) && bcd_q[4*i +: 4] != 4'd0) lead_blank = 1'b0;
`endif
  end

  always_comb begin
    case (sel_digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
    if (lead_blank) seg_next = 7'b1111111;
    if (ovf_q)      seg_next = 7'b0111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg_q       <= 7'b1111111;
      an_q        <= '1;
    end else begin
      if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an_q  <= ~(DIGITS'(1) << digit_idx);
      seg_q <= seg_next;
    end
  end

  assign bus.busy     = busy;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.seg_n    = seg_q;
  assign bus.an_n     = an_q;

endmodule

// File: tb/tb_seg_result_display.sv
// Bench for seg_result_display: a 4-digit and a 3-digit instance share one stimulus stream and are
// checked against table vectors and an arithmetic reference model.
module tb_seg_result_display;
  localparam int VW  = 12;
  localparam int REF = 2;

  logic          clk;
  logic          rst;
  logic [VW-1:0] value;
  logic          valid;
  int            edge_cnt = 0;
  int            errors = 0;
  int            checks = 0;
  int unsigned   cur_val = 0;

  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  seg_result_display_if #(.VAL_W(VW), .DIGITS(4)) if4 ();
  seg_result_display_if #(.VAL_W(VW), .DIGITS(3)) if3 ();

  assign if4.value_in    = value;
  assign if4.value_valid = valid;
  assign if3.value_in    = value;
  assign if3.value_valid = valid;

  seg_result_display #(.VAL_W(VW), .DIGITS(4), .REFRESH_DIV(REF)) dut4 (
    .clk(clk), .rst(rst), .bus(if4));
  seg_result_display #(.VAL_W(VW), .DIGITS(3), .REFRESH_DIV(REF)) dut3 (
    .clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v, input int d);
    int unsigned m = v % pow10(d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v, input int d, input int i);
    int unsigned m = v % pow10(d);
    if (v >= pow10(d)) return 7'b0111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (i > 0 && m < pow10(i)) return 7'b1111111;
`endif
    return SEG_TAB[(m / pow10(i)) % 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge; returns at the first negedge with both instances idle.
  task automatic strobe(input int unsigned v);
    int n4 = 0;
    int n3 = 0;
    value = VW'(v);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if4.busy) n4++;
      if (if3.busy) n3++;
      if (!if4.busy && !if3.busy) break;
      @(negedge clk);
    end
    check("busy_len4", n4, VW + 1);
    check("busy_len3", n3, VW + 1);
    cur_val = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!if4.busy && !if3.busy) break;
      @(negedge clk);
    end
    check("idle_timeout", {if4.busy, if3.busy}, 0);
  endtask

  task automatic check_outputs(input int unsigned v);
    check("bcd4", if4.bcd_out, to_bcd(v, 4));
    check("ovf4", if4.overflow, v >= 10000);
    check("bcd3", if3.bcd_out, to_bcd(v, 3));
    check("ovf3", if3.overflow, v >= 1000);
  endtask

  task automatic check_display(input int ncyc);
    @(negedge clk);
    for (int c = 0; c < ncyc; c++) begin
      int i4, i3;
      logic [3:0] a4;
      logic [2:0] a3;
      i4 = ((edge_cnt - 1) / REF) % 4;
      i3 = ((edge_cnt - 1) / REF) % 3;
      a4 = ~(4'b0001 << i4);
      a3 = ~(3'b001 << i3);
      check("an4", if4.an_n, a4);
      check("seg4", if4.seg_n, model_seg(cur_val, 4, i4));
      check("an3", if3.an_n, a3);
      check("seg3", if3.seg_n, model_seg(cur_val, 3, i3));
      @(negedge clk);
    end
  endtask

  typedef struct {
    int unsigned value;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [11:0] bcd3;
    logic        ovf3;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1234, 16'h1234, 1'b0, 12'h234, 1'b1};
    vecs[1] = '{7,    16'h0007, 1'b0, 12'h007, 1'b0};
    vecs[2] = '{0,    16'h0000, 1'b0, 12'h000, 1'b0};
    vecs[3] = '{1000, 16'h1000, 1'b0, 12'h000, 1'b1};
    vecs[4] = '{999,  16'h0999, 1'b0, 12'h999, 1'b0};
    vecs[5] = '{4095, 16'h4095, 1'b0, 12'h095, 1'b1};
    vecs[6] = '{10,   16'h0010, 1'b0, 12'h010, 1'b0};

    rst   = 1'b1;
    value = '0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_seg4", if4.seg_n, 7'b1111111);
    check("rst_an4", if4.an_n, 4'b1111);
    check("rst_an3", if3.an_n, 3'b111);
    check("rst_bcd4", if4.bcd_out, 0);
    check("rst_busy4", if4.busy, 0);
    check("rst_ovf3", if3.overflow, 0);
    @(posedge clk);
    #1;
    check("first_an4", if4.an_n, 4'b1110);
    check("first_seg4", if4.seg_n, 7'b1000000);
    check("first_an3", if3.an_n, 3'b110);
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      strobe(vecs[k].value);
      check("vec_bcd4", if4.bcd_out, vecs[k].bcd4);
      check("vec_ovf4", if4.overflow, vecs[k].ovf4);
      check("vec_bcd3", if3.bcd_out, vecs[k].bcd3);
      check("vec_ovf3", if3.overflow, vecs[k].ovf3);
      check_display(10);
    end

    // Strobe during conversion is dropped.
    strobe(4095);
    value = VW'(1);
    valid = 1'b1;
    strobe(4095);
    valid = 1'b0;
    value = VW'(4095);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    value = VW'(1);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    check_outputs(4095);
    repeat (20) @(negedge clk);
    check("drop_busy", if4.busy, 0);
    check_outputs(4095);

    // Reset mid-conversion aborts without committing.
    value = VW'(321);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", if4.busy, 0);
    check("midrst_bcd4", if4.bcd_out, 0);
    check("midrst_ovf3", if3.overflow, 0);
    check("midrst_seg", if4.seg_n, 7'b1111111);
    check("midrst_an", if4.an_n, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    cur_val = 0;
    repeat (20) @(negedge clk);
    check("midrst_nocommit", if4.bcd_out, 0);
    check_display(4);

    // Strobe on the edge where busy falls is ignored; the next one is taken.
    value = VW'(100);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (12) @(negedge clk);
    check("commit_busy", if4.busy, 1);
    value = VW'(200);
    valid = 1'b1;
    @(negedge clk);
    check("fall_busy", if4.busy, 0);
    check("fall_bcd4", if4.bcd_out, 16'h0100);
    @(negedge clk);
    valid = 1'b0;
    check("next_busy", if4.busy, 1);
    wait_idle();
    check_outputs(200);
    cur_val = 200;
    check_display(6);

    for (int r = 0; r < 24; r++) begin
      int unsigned v;
      v = $urandom_range(0, 4095);
      strobe(v);
      check_outputs(v);
      if (r % 4 == 0) check_display(6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_result_display.md
# seg_result_display

Downstream display stage for the convolution layer: captures the layer's binary result on a one-cycle strobe, converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a common-anode 7-segment display. The layer's output word feeds `value_in`, truncated to `VAL_W` bits. The board pin constraints drive `seg_n`/`an_n`.

## Interface
- `VAL_W`, 12, width of the binary input value (≥ 4).
- `DIGITS`, 4, number of decimal digits converted and displayed (1–8).
- `REFRESH_DIV`, 50000, clocks each digit stays selected (≥ 1).
- `clk  in  1`  clock clk.
- `rst  in  1`  reset rst, asynchronous, active-high.
- `value_in  in  VAL_W`  unsigned value to display.
- `value_valid  in  1`  capture strobe, sampled on rising `clk`.
- `busy  out  1`  conversion in progress; strobes ignored while high.
- `bcd_out  out  4*DIGITS`  packed BCD of last committed value, digit 0 (units) in [3:0].
- `overflow  out  1`  last committed value ≥ 10^DIGITS.
- `seg_n  out  7`  active-low segments {g,f,e,d,c,b,a}.
- `an_n  out  DIGITS`  active-low digit enables, one-hot-low.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE: on `value_valid`=1 → latch `value_in` into shift register, clear DIGITS-digit scratch BCD, iteration counter 0, latch overflow flag (value ≥ 10^DIGITS, compile-time constant) → CONVERT.
- CONVERT: each cycle, add 3 to every scratch digit ≥ 5, then shift {scratch, shift reg} left 1; counter +1; after VAL_W iterations → COMMIT. Bits shifted out of the top digit are discarded (result = value mod 10^DIGITS).
- COMMIT: `bcd_out` ← scratch, `overflow` ← latched flag → IDLE.
- `value_valid` in CONVERT or COMMIT: dropped, no queueing, no side effect.
- Display mux: refresh counter 0..REFRESH_DIV-1; on wrap, digit index advances 0→DIGITS-1→0. Independent of FSM.
- Segment decode of selected committed digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (g..a). Codes 10–15 unreachable, decode blank 1111111.
- `overflow`=1: every digit shows dash 0111111.
- `bcd_out`/`overflow` change only in COMMIT; display never shows partial conversion.

## Timing
- Reset values: `busy` 0, `bcd_out` 0, `overflow` 0, `seg_n` 1111111, `an_n` all 1, FSM IDLE, refresh counter 0, digit index 0.
- Strobe sampled at edge E0 → `busy` 1 after E0; `bcd_out`/`overflow` update and `busy` 0 after edge E0+VAL_W+1. `busy` high exactly VAL_W+1 cycles.
- Strobe at the edge where `busy` falls is ignored (state is COMMIT); strobe at next edge accepted. Back-to-back throughput: one value per VAL_W+2 cycles.
- `seg_n`, `an_n` registered: reflect digit index and committed data one cycle later; first valid drive after first edge out of reset (`an_n` bit 0 low, `seg_n` "0").
- Digit index wraps DIGITS-1 → 0 with no blank cycle.
- `rst` mid-conversion: aborts immediately, all outputs to reset values; no partial commit.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined: digits above the most significant non-zero committed digit drive 1111111 (anode still cycles); digit 0 always shown, so value 0 shows single "0". Overflow dashes take precedence.
- Not defined: all DIGITS digits shown, leading zeros displayed as "0".

## Test plan
- Reset, then 1 clk, REFRESH_DIV=2 → before edge `seg_n`=1111111, `an_n`=1111, `bcd_out`=0, `busy`=0; after edge `an_n`=1110, `seg_n`=1000000.
- `value_in`=1234, strobe 1 cycle → `busy` high 13 cycles, then `bcd_out`=16'h1234, `overflow`=0.
- `value_in`=4095, strobe; second strobe (`value_in`=1) 5 cycles later → `bcd_out`=16'h4095, second value never appears; repeat with `rst` pulsed at cycle 6 → `bcd_out`=0, `busy`=0.
- REFRESH_DIV=2, committed 16'h1234 → `an_n` sequence 1110,1101,1011,0111,1110 each 2 clocks; `seg_n` 0011001(4),0110000(3),0100100(2),1111001(1).
- DIGITS=3, `value_in`=1000 → `overflow`=1, all digits 0111111, `bcd_out`=12'h000; then 999 → `overflow`=0, `bcd_out`=12'h999.
- `value_in`=7 → with `SEG_LEADING_ZERO_BLANK_EN` digits 3..1 1111111, digit 0 1111000; without, digits 3..1 1000000; `value_in`=0 with macro → only digit 0 shows 1000000.
